pwm_decoder: RTL and testbench
==============================

// Module: pwm_decoder
// PURPOSE
//  Receive side of the LED PWM link: recovers the 8-bit duty level from a PWM waveform
//  (high for L clocks out of a PERIOD-clock frame, frame starts on rising edge).
//  Used for loopback checking of the PWM generator and to accept dimming input on a header pin.
//  Handles 0%/100% duty (no edges) via timeout; flags frames of the wrong length.
// PARAMETERS
//  PERIOD   256  expected frame length in ICE_CLK cycles
//  TOL      2    accepted |measured period - PERIOD| in cycles
//  TIMEOUT  512  cycles without a rising edge before input is declared stuck (> PERIOD+TOL)
// PORTS
//  ICE_CLK      in   1  system clock; all logic on posedge
//  RST          in   1  synchronous, active-high reset
//  pwm_in       in   1  asynchronous PWM input
//  level        out  8  last decoded duty level
//  level_valid  out  1  one-cycle pulse when level is (re)written
//  locked       out  1  1 = last frame good or input stuck; 0 = unsynced/bad frame
//  period_err   out  1  1 = last completed frame failed the PERIOD+/-TOL check
// BEHAVIOUR
//  Reset: level=0, level_valid=0, locked=0, period_err=0, sync flops=0, prev=0, counters=0, state=IDLE.
//  Input path: 2-flop synchronizer s1->s2, then prev<=s2; rise = s2 & ~prev.
//   Pin rising before clock k -> rise asserted in cycle k+2 (s2 high, prev low).
//  Counters (9+ bits, wide enough for TIMEOUT, saturate at TIMEOUT):
//   rise cycle: period_cnt<=1, high_cnt<=1.
//   other cycles: period_cnt+=1; high_cnt+=s2.
//   At the next rise, period_cnt equals the frame length and high_cnt equals the high-cycle count.
//  States:
//   IDLE    : no frame reference. rise -> MEASURE (no output). period_cnt==TIMEOUT -> STUCK.
//   MEASURE : on rise, evaluate the completed frame:
//             if |period_cnt-PERIOD|<=TOL: level<=min(high_cnt,255), level_valid pulse,
//               locked<=1, period_err<=0;
//             else: period_err<=1, locked<=0, level held, no pulse.
//             Counters restart; stay in MEASURE.
//             period_cnt==TIMEOUT with no rise -> STUCK.
//   STUCK   : on entry (same cycle as the transition), level<=s2?8'hFF:8'h00, level_valid pulse
//             (once), locked<=1, period_err<=0.
//             rise -> MEASURE; partial first frame produces no output.
//  Outputs are registered; level and level_valid change together.
//  level_valid is never high on two consecutive cycles.
//  Simultaneous rise and timeout in the same cycle: rise wins (frame evaluated, no STUCK).
//  Saturation: high_cnt clamps at 255 for level; period_cnt clamps at TIMEOUT.
//  Reset mid-frame: everything returns to reset values next cycle.
//   If pwm_in is high, a spurious rise is seen 2 cycles after reset release; it only moves
//   IDLE->MEASURE and emits no level.
// TESTING
//  1. Model PWM, PERIOD=256, L=0x80, free-running
//     -> from the 2nd rise on: level=0x80, level_valid pulse every 256 cycles, locked=1, period_err=0.
//  2. Hold pwm_in=0 after L=0x40 frames
//     -> one level_valid with level=0x00 exactly TIMEOUT cycles after the last rise, locked=1.
//  3. Hold pwm_in=1
//     -> STUCK, level=0xFF with a single pulse. Then resume L=0x10 frames
//     -> first full frame after resume gives level=0x10.
//  4. Frame length 300, L=0x20
//     -> period_err=1, locked=0, level keeps its previous value, no pulse.
//     Frame length 257 -> accepted.
//  5. Assert RST for 1 cycle mid-frame with pwm_in high
//     -> all outputs 0. Next valid level appears after the second full frame.
//  6. Breathing sweep L=0x00..0xFE..0x01, one step per frame
//     -> each decoded level equals the generated level of the preceding frame; L=0 frames yield 0 via timeout.

Source files
------------

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the 8-bit duty level of a PWM frame stream, detects a stuck pin and bad frame lengths.
// Latency: pin edge seen as a rise 2 cycles later; outputs update 1 cycle after the deciding rise or timeout.
// Backpressure: none; level_valid is a single-cycle strobe that the consumer must take when it fires.
module pwm_decoder #(
  parameter int PERIOD  = 256,
  parameter int TOL     = 2,
  parameter int TIMEOUT = 512
) (
  input  logic       ICE_CLK,
  input  logic       RST,
  input  logic       pwm_in,
  output logic [7:0] level,
  output logic       level_valid,
  output logic       locked,
  output logic       period_err
);

  // Counter must hold TIMEOUT itself, since both counters park there.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] PER_LO    = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] PER_HI    = CW'(PERIOD + TOL);
  localparam logic [CW-1:0] LVL_MAX   = CW'(255);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK
  } state_t;

  state_t          state;
  state_t          state_d;
  logic            s1;
  logic            s2;
  logic            prev;
  logic            rise;
  logic [CW-1:0]   period_cnt;
  logic [CW-1:0]   high_cnt;
  logic            timeout;
  logic            frame_ok;
  logic [7:0]      level_meas;
  logic            go_stuck;
  logic [7:0]      level_d;
  logic            valid_d;
  logic            locked_d;
  logic            err_d;

  assign rise       = s2 & ~prev;
  assign timeout    = (period_cnt == TIMEOUT_C);
  assign frame_ok   = (period_cnt >= PER_LO) && (period_cnt <= PER_HI);
  // A frame can be high for more than 255 cycles when it runs a little long.
  assign level_meas = (high_cnt > LVL_MAX) ? 8'hFF : high_cnt[7:0];

  // Two-flop synchronizer for the asynchronous pin plus one delay stage for edge detection.
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Frame length and high-time counters; the rise cycle itself counts as cycle 1 of the new frame.
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CW'(1);
      high_cnt   <= CW'(1);
    end else begin
      if (period_cnt != TIMEOUT_C) begin
        period_cnt <= period_cnt + CW'(1);
      end
      if (s2 && (high_cnt != TIMEOUT_C)) begin
        high_cnt <= high_cnt + CW'(1);
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      state       <= IDLE;
      level       <= 8'h00;
      level_valid <= 1'b0;
      locked      <= 1'b0;
      period_err  <= 1'b0;
    end else begin
      state       <= state_d;
      level       <= level_d;
      level_valid <= valid_d;
      locked      <= locked_d;
      period_err  <= err_d;
    end
  end

  // Next state and next outputs; a rise always beats a timeout landing on the same cycle.
  always_comb begin
    state_d  = state;
    level_d  = level;
    valid_d  = 1'b0;
    locked_d = locked;
    err_d    = period_err;
    go_stuck = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
        end else if (timeout) begin
          go_stuck = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          if (frame_ok) begin
            level_d  = level_meas;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            err_d    = 1'b0;
          end else begin
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end else if (timeout) begin
          go_stuck = 1'b1;
        end
      end
      STUCK: begin
        // The first frame after a stuck period is partial, so it only re-arms measurement.
        if (rise) begin
          state_d = MEASURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Entering STUCK reports the held pin value once as a 0% or 100% duty level.
    if (go_stuck) begin
      state_d  = STUCK;
      level_d  = s2 ? 8'hFF : 8'h00;
      valid_d  = 1'b1;
      locked_d = 1'b1;
      err_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: drives PWM frame sequences into pwm_decoder and checks against a frame-level reference model.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable; the bench only observes level_valid strobes.
module tb_pwm_decoder;

  localparam int PERIOD  = 256;
  localparam int TOL     = 2;
  localparam int TIMEOUT = 512;
  localparam int MAXC    = 60000;

  localparam int M_IDLE  = 0;
  localparam int M_MEAS  = 1;
  localparam int M_STUCK = 2;

  logic       ICE_CLK = 1'b0;
  logic       RST;
  logic       pwm_in;
  logic [7:0] level;
  logic       level_valid;
  logic       locked;
  logic       period_err;

  int checks = 0;
  int errors = 0;

  // Pin and reset history indexed by clock edge; the model derives everything from these.
  bit pin_hist [MAXC];
  bit rst_hist [MAXC];
  int ecount = 0;

  // Reference model state: expected outputs and the edge at which the current frame began.
  int         m_mode  = M_IDLE;
  int         m_ref   = 0;
  logic [7:0] m_level = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_locked = 1'b0;
  logic       m_err   = 1'b0;
  bit         armed   = 1'b0;

  // Observation bookkeeping.
  int         diverge      = 0;
  string      div_msg      = "";
  int         pulses       = 0;
  int         m_pulses     = 0;
  int         last_pulse_e = -1;
  int         last_gap     = 0;
  logic [7:0] first_level  = 8'h00;

  pwm_decoder #(
    .PERIOD (PERIOD),
    .TOL    (TOL),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .ICE_CLK    (ICE_CLK),
    .RST        (RST),
    .pwm_in     (pwm_in),
    .level      (level),
    .level_valid(level_valid),
    .locked     (locked),
    .period_err (period_err)
  );

  always #5 ICE_CLK = ~ICE_CLK;

  // Pin value as the decoder sees it at edge e: two cycles of synchronizer delay, cleared by reset.
  function automatic bit seen(input int e);
    if (e < 2) return 1'b0;
    if (rst_hist[e-1] || rst_hist[e-2]) return 1'b0;
    return pin_hist[e-2];
  endfunction

  // One clock: apply inputs, advance the frame-level model at the edge, then sample the DUT.
  task automatic tick(input bit p, input bit r);
    int e;
    int len;
    int hs;
    bit rz;
    pwm_in = p;
    RST    = r;
    @(posedge ICE_CLK);
    e = ecount;
    if (e >= MAXC) begin
      $display("FAIL cycle_budget: used %0d cycles, limit %0d", e, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    pin_hist[e] = p;
    rst_hist[e] = r;
    ecount++;
    if (r) begin
      m_mode   = M_IDLE;
      m_ref    = e + 1;
      m_level  = 8'h00;
      m_valid  = 1'b0;
      m_locked = 1'b0;
      m_err    = 1'b0;
      armed    = 1'b1;
    end else begin
      m_valid = 1'b0;
      rz  = seen(e) && !seen(e-1);
      len = e - m_ref;
      if (rz) begin
        if (m_mode == M_MEAS) begin
          if (len >= PERIOD - TOL && len <= PERIOD + TOL) begin
            hs = 0;
            for (int i = m_ref; i < e; i++) hs += int'(seen(i));
            m_level  = (hs > 255) ? 8'hFF : 8'(hs);
            m_valid  = 1'b1;
            m_locked = 1'b1;
            m_err    = 1'b0;
          end else begin
            m_locked = 1'b0;
            m_err    = 1'b1;
          end
        end
        m_mode = M_MEAS;
        m_ref  = e;
      end else if (m_mode != M_STUCK && len == TIMEOUT) begin
        m_mode   = M_STUCK;
        m_level  = seen(e) ? 8'hFF : 8'h00;
        m_valid  = 1'b1;
        m_locked = 1'b1;
        m_err    = 1'b0;
      end
    end
    #1;
    if (armed && ({level, level_valid, locked, period_err} !== {m_level, m_valid, m_locked, m_err})) begin
      if (diverge == 0) begin
        div_msg = $sformatf("first at cycle %0d: got lvl=%h vld=%b lck=%b err=%b, expected lvl=%h vld=%b lck=%b err=%b",
                            e, level, level_valid, locked, period_err, m_level, m_valid, m_locked, m_err);
      end
      diverge++;
    end
    if (m_valid) m_pulses++;
    if (level_valid === 1'b1) begin
      if (pulses == 0) first_level = level;
      if (last_pulse_e >= 0) last_gap = e - last_pulse_e;
      last_pulse_e = e;
      pulses++;
    end
  endtask

  task automatic frame(input int len, input int hi);
    for (int i = 0; i < len; i++) tick(i < hi, 1'b0);
  endtask

  task automatic hold(input int n, input bit v);
    for (int i = 0; i < n; i++) tick(v, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    checks++;
    if ({level, level_valid, locked, period_err} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got lvl=%h vld=%b lck=%b err=%b, expected all zero", level, level_valid, locked, period_err);
    end
    tick(1'b0, 1'b0);
    diverge = 0;
  endtask

  task automatic test_free_run();
    pulses = 0;
    for (int f = 0; f < 6; f++) frame(PERIOD, 8'h80);
    checks++;
    if (pulses !== 5) begin
      errors++; $display("FAIL free_run_pulses: got %0d, expected 5", pulses);
    end
    checks++;
    if (level !== 8'h80 || locked !== 1'b1 || period_err !== 1'b0) begin
      errors++; $display("FAIL free_run_level: got lvl=%h lck=%b err=%b, expected 80/1/0", level, locked, period_err);
    end
    checks++;
    if (last_gap !== PERIOD) begin
      errors++; $display("FAIL free_run_gap: got %0d cycles, expected %0d", last_gap, PERIOD);
    end
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL free_run_model: %0d cycles differ, %s", diverge, div_msg);
    end
    diverge = 0;
  endtask

  task automatic test_stuck_low();
    pulses = 0;
    for (int f = 0; f < 3; f++) frame(PERIOD, 8'h40);
    hold(600, 1'b0);
    checks++;
    if (pulses !== 4) begin
      errors++; $display("FAIL stuck_low_pulses: got %0d, expected 4", pulses);
    end
    checks++;
    if (level !== 8'h00 || locked !== 1'b1 || period_err !== 1'b0) begin
      errors++; $display("FAIL stuck_low_level: got lvl=%h lck=%b err=%b, expected 00/1/0", level, locked, period_err);
    end
    checks++;
    if (last_gap !== TIMEOUT) begin
      errors++; $display("FAIL stuck_low_gap: got %0d cycles, expected %0d", last_gap, TIMEOUT);
    end
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL stuck_low_model: %0d cycles differ, %s", diverge, div_msg);
    end
    diverge = 0;
  endtask

  task automatic test_stuck_high();
    pulses = 0;
    hold(600, 1'b1);
    checks++;
    if (pulses !== 1 || level !== 8'hFF || locked !== 1'b1) begin
      errors++; $display("FAIL stuck_high: got pulses=%0d lvl=%h lck=%b, expected 1/FF/1", pulses, level, locked);
    end
    pulses = 0;
    for (int f = 0; f < 5; f++) frame(PERIOD, 8'h10);
    checks++;
    if (pulses !== 3 || first_level !== 8'h10) begin
      errors++; $display("FAIL resume_after_high: got pulses=%0d first=%h, expected 3/10", pulses, first_level);
    end
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL stuck_high_model: %0d cycles differ, %s", diverge, div_msg);
    end
    diverge = 0;
  endtask

  task automatic test_period_err();
    int p0;
    for (int f = 0; f < 3; f++) frame(PERIOD, 8'h30);
    frame(300, 8'h20);
    p0 = pulses;
    hold(3, 1'b1);
    checks++;
    if (period_err !== 1'b1 || locked !== 1'b0 || level !== 8'h30 || pulses !== p0) begin
      errors++;
      $display("FAIL long_frame: got err=%b lck=%b lvl=%h pulses=%0d, expected 1/0/30/%0d", period_err, locked, level, pulses, p0);
    end
    for (int i = 3; i < 257; i++) tick(i < 8'h20, 1'b0);
    hold(3, 1'b1);
    checks++;
    if (period_err !== 1'b0 || locked !== 1'b1 || level !== 8'h20 || pulses !== p0 + 1) begin
      errors++;
      $display("FAIL frame_257: got err=%b lck=%b lvl=%h pulses=%0d, expected 0/1/20/%0d", period_err, locked, level, pulses, p0 + 1);
    end
    for (int i = 3; i < PERIOD; i++) tick(i < 8'h20, 1'b0);
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL period_err_model: %0d cycles differ, %s", diverge, div_msg);
    end
    diverge = 0;
  endtask

  task automatic test_reset_mid();
    frame(PERIOD, 8'hA0);
    frame(PERIOD, 8'hA0);
    hold(50, 1'b1);
    tick(1'b1, 1'b1);
    checks++;
    if ({level, level_valid, locked, period_err} !== 11'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got lvl=%h vld=%b lck=%b err=%b, expected all zero", level, level_valid, locked, period_err);
    end
    pulses = 0;
    for (int i = 51; i < PERIOD; i++) tick(i < 8'hA0, 1'b0);
    for (int f = 0; f < 3; f++) frame(PERIOD, 8'hA0);
    checks++;
    if (pulses !== 2 || first_level !== 8'hA0 || level !== 8'hA0) begin
      errors++;
      $display("FAIL reset_mid_recover: got pulses=%0d first=%h lvl=%h, expected 2/A0/A0", pulses, first_level, level);
    end
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL reset_mid_model: %0d cycles differ, %s", diverge, div_msg);
    end
    diverge = 0;
  endtask

  task automatic test_breathing();
    int step;
    int l;
    step = int'($urandom_range(6, 14));
    frame(2 * PERIOD, 0);
    checks++;
    if (level !== 8'h00 || locked !== 1'b1) begin
      errors++; $display("FAIL breathe_zero: got lvl=%h lck=%b, expected 00/1", level, locked);
    end
    pulses   = 0;
    m_pulses = 0;
    for (l = step; l < 8'hFE; l += step) frame(PERIOD, l);
    frame(PERIOD, 8'hFE);
    for (l = 8'hFE - step; l > 1; l -= step) frame(PERIOD, l);
    frame(PERIOD, 1);
    hold(3, 1'b1);
    checks++;
    if (level !== 8'h01 || locked !== 1'b1 || pulses !== m_pulses) begin
      errors++;
      $display("FAIL breathe_end: got lvl=%h lck=%b pulses=%0d, expected 01/1/%0d", level, locked, pulses, m_pulses);
    end
    for (int i = 3; i < PERIOD; i++) tick(1'b0, 1'b0);
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL breathe_model: %0d cycles differ, %s", diverge, div_msg);
    end
    diverge = 0;
  endtask

  task automatic test_boundaries();
    frame(PERIOD, 8'h40);
    frame(258, 257);
    hold(3, 1'b1);
    checks++;
    if (level !== 8'hFF || period_err !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL high_clamp: got lvl=%h err=%b lck=%b, expected FF/0/1", level, period_err, locked);
    end
    for (int i = 3; i < PERIOD; i++) tick(i < 8'h40, 1'b0);
    frame(TIMEOUT, 8'h10);
    hold(3, 1'b1);
    checks++;
    if (level !== 8'h40 || period_err !== 1'b1 || locked !== 1'b0) begin
      errors++; $display("FAIL rise_vs_timeout: got lvl=%h err=%b lck=%b, expected 40/1/0", level, period_err, locked);
    end
    for (int i = 3; i < PERIOD; i++) tick(i < 8'h40, 1'b0);
    frame(254, 8'h50);
    frame(259, 8'h60);
    hold(3, 1'b1);
    checks++;
    if (level !== 8'h50 || period_err !== 1'b1 || locked !== 1'b0) begin
      errors++; $display("FAIL tol_edges: got lvl=%h err=%b lck=%b, expected 50/1/0", level, period_err, locked);
    end
    for (int i = 3; i < PERIOD; i++) tick(i < 8'h40, 1'b0);
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL boundaries_model: %0d cycles differ, %s", diverge, div_msg);
    end
    diverge = 0;
  endtask

  task automatic test_random();
    int len;
    int hi;
    pulses   = 0;
    m_pulses = 0;
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 1) == 1) len = int'($urandom_range(252, 260));
      else len = int'($urandom_range(200, 500));
      hi = int'($urandom_range(1, len - 1));
      frame(len, hi);
    end
    hold(3, 1'b1);
    checks++;
    if (pulses !== m_pulses) begin
      errors++; $display("FAIL random_pulses: got %0d, expected %0d", pulses, m_pulses);
    end
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL random_model: %0d cycles differ, %s", diverge, div_msg);
    end
    diverge = 0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stuck_low();
    test_stuck_high();
    test_period_err();
    test_reset_mid();
    test_breathing();
    test_boundaries();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached after %0d cycles", ecount);
    $fatal(1, "watchdog");
  end

endmodule
